// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared widths, FSM encoding and the register-match helper for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_FILE_ADDR_LEN = 5;
  localparam int unsigned WAIT_CNT_W        = 8;
  localparam int unsigned STALL_CNT_W       = 16;
  localparam int unsigned MEM_TIMEOUT_DEF   = 255;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  // A writing stage conflicts with ID when its non-zero destination matches a source read.
  function automatic logic src_hit(
    input logic [REG_FILE_ADDR_LEN-1:0] dest,
    input logic                         wb_en,
    input logic [REG_FILE_ADDR_LEN-1:0] src1,
    input logic [REG_FILE_ADDR_LEN-1:0] src2,
    input logic                         two_src
  );
    return wb_en && (dest != '0) && ((dest == src1) || (two_src && (dest == src2)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard comparator: load-use only when forwarding, full RAW check otherwise.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_FILE_ADDR_LEN-1:0] id_src1,
  input  logic [REG_FILE_ADDR_LEN-1:0] id_src2,
  input  logic                         id_two_src,
  input  logic [REG_FILE_ADDR_LEN-1:0] exe_dest,
  input  logic                         exe_wb_en,
  input  logic                         exe_mem_r_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
  input  logic                         mem_wb_en,
  input  logic                         fwd_en,
  output logic                         hazard
);

  logic exe_hit;
  logic mem_hit;

  assign exe_hit = src_hit(exe_dest, exe_wb_en, id_src1, id_src2, id_two_src);
  assign mem_hit = src_hit(mem_dest, mem_wb_en, id_src1, id_src2, id_two_src);

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign hazard = fwd_en ? (exe_hit && exe_mem_r_en) : (exe_hit || mem_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, stall/flush generation and stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REG_FILE_ADDR_LEN-1:0] id_src1,
  input  logic [REG_FILE_ADDR_LEN-1:0] id_src2,
  input  logic                         id_two_src,
  input  logic [REG_FILE_ADDR_LEN-1:0] exe_dest,
  input  logic                         exe_wb_en,
  input  logic                         exe_mem_r_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
  input  logic                         mem_wb_en,
  input  logic                         fwd_en,
  input  logic                         br_taken,
  input  logic                         mem_req,
  input  logic                         mem_ready,
  output logic                         freeze_pc,
  output logic                         freeze_ifid,
  output logic                         flush_ifid,
  output logic                         bubble_idexe,
  output logic                         freeze_all,
  output logic                         mem_err,
  output logic [STALL_CNT_W-1:0]       stall_cnt
);

  state_e                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  hazard;
  logic                  frz;

  hazard_detect u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .fwd_en       (fwd_en),
    .hazard       (hazard)
  );

  // State, wait counter, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      if ((freeze_all || freeze_pc) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
      case (state)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state <= ST_RUN;
          end else begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
            if (wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT - 1)) begin
              state   <= ST_ERR;
              mem_err <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // Hazard outputs; a global freeze masks branch and hazard handling until it releases.
  always_comb begin
    frz          = 1'b0;
    freeze_all   = 1'b0;
    freeze_pc    = 1'b0;
    freeze_ifid  = 1'b0;
    flush_ifid   = 1'b0;
    bubble_idexe = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN:      frz = mem_req && !mem_ready;
        ST_MEM_WAIT: frz = !mem_ready;
        ST_ERR:      frz = 1'b1;
        default:     frz = 1'b0;
      endcase
      freeze_all = frz;
      if (!frz) begin
        if (br_taken) begin
          flush_ifid   = 1'b1;
          bubble_idexe = 1'b1;
        end else if (hazard) begin
          freeze_pc    = 1'b1;
          freeze_ifid  = 1'b1;
          bubble_idexe = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with a short memory timeout.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_src1;
  logic [4:0]  id_src2;
  logic        id_two_src;
  logic [4:0]  exe_dest;
  logic        exe_wb_en;
  logic        exe_mem_r_en;
  logic [4:0]  mem_dest;
  logic        mem_wb_en;
  logic        fwd_en;
  logic        br_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        freeze_pc;
  logic        freeze_ifid;
  logic        flush_ifid;
  logic        bubble_idexe;
  logic        freeze_all;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic [4:0]  outs;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .fwd_en       (fwd_en),
    .br_taken     (br_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .freeze_pc    (freeze_pc),
    .freeze_ifid  (freeze_ifid),
    .flush_ifid   (flush_ifid),
    .bubble_idexe (bubble_idexe),
    .freeze_all   (freeze_all),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  assign outs = {freeze_all, freeze_pc, freeze_ifid, flush_ifid, bubble_idexe};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
    exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = '0; mem_wb_en = 1'b0;
    fwd_en = 1'b0; br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    fwd_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 5'd5; id_src1 = 5'd5;
    mem_req = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL reset_outs_forced got %b exp %b", outs, 5'b00000);
    end
    tick();
    tick();
    checks++;
    if (stall_cnt !== 16'd0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL reset_regs got stall=%0d err=%b exp stall=0 err=0", stall_cnt, mem_err);
    end
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL reset_idle_outs got %b exp %b", outs, 5'b00000);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    fwd_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 5'd5; id_src1 = 5'd5;
    #1;
    checks++;
    if (outs !== 5'b01101) begin
      errors++; $display("FAIL load_use_stall got %b exp %b", outs, 5'b01101);
    end
    tick();
    exe_mem_r_en = 1'b0;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL load_use_release got %b exp %b", outs, 5'b00000);
    end
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_stall_cnt got %0d exp %0d", stall_cnt, 1);
    end
    // src2 match counts only when the instruction reads two registers
    exe_mem_r_en = 1'b1; id_src1 = 5'd1; id_src2 = 5'd5; id_two_src = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b01101) begin
      errors++; $display("FAIL load_use_src2 got %b exp %b", outs, 5'b01101);
    end
    exe_dest = 5'd0; id_src1 = 5'd0; id_src2 = 5'd0;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL load_use_r0 got %b exp %b", outs, 5'b00000);
    end
    clear_inputs();
  endtask

  task automatic test_raw_no_fwd();
    apply_reset();
    fwd_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 5'd7; id_src2 = 5'd7; id_two_src = 1'b1; id_src1 = 5'd2;
    #1;
    checks++;
    if (outs !== 5'b01101) begin
      errors++; $display("FAIL raw_mem_src2 got %b exp %b", outs, 5'b01101);
    end
    id_two_src = 1'b0;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL raw_single_src got %b exp %b", outs, 5'b00000);
    end
    mem_dest = 5'd0; id_src2 = 5'd0; id_two_src = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL raw_r0 got %b exp %b", outs, 5'b00000);
    end
    mem_wb_en = 1'b0; exe_wb_en = 1'b1; exe_dest = 5'd3; id_src1 = 5'd3;
    #1;
    checks++;
    if (outs !== 5'b01101) begin
      errors++; $display("FAIL raw_exe_src1 got %b exp %b", outs, 5'b01101);
    end
    fwd_en = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL fwd_non_load got %b exp %b", outs, 5'b00000);
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    apply_reset();
    fwd_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 5'd5; id_src1 = 5'd5;
    br_taken = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00011) begin
      errors++; $display("FAIL branch_over_hazard got %b exp %b", outs, 5'b00011);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL branch_no_stall_cnt got %0d exp %0d", stall_cnt, 0);
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0; br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== 5'b10000) begin
        errors++; $display("FAIL mem_wait_frozen cyc %0d got %b exp %b", i, outs, 5'b10000);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00011) begin
      errors++; $display("FAIL mem_wait_release got %b exp %b", outs, 5'b00011);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL mem_wait_back_to_run got %b exp %b", outs, 5'b00000);
    end
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++; $display("FAIL mem_wait_stall_cnt got %0d exp %0d", stall_cnt, 3);
    end
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL mem_ready_now got %b exp %b", outs, 5'b00000);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (mem_err !== 1'b0 || freeze_all !== 1'b1) begin
        errors++; $display("FAIL timeout_waiting cyc %0d got err=%b frz=%b exp err=0 frz=1", i, mem_err, freeze_all);
      end
      tick();
    end
    checks++;
    if (mem_err !== 1'b1 || freeze_all !== 1'b1) begin
      errors++; $display("FAIL timeout_err got err=%b frz=%b exp err=1 frz=1", mem_err, freeze_all);
    end
    mem_ready = 1'b1; br_taken = 1'b1;
    tick();
    tick();
    checks++;
    if (outs !== 5'b10000 || mem_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b err=%b exp %b err=1", outs, mem_err, 5'b10000);
    end
    clear_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL err_rst_forced got %b exp %b", outs, 5'b00000);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (mem_err !== 1'b0 || stall_cnt !== 16'd0 || freeze_all !== 1'b0) begin
      errors++; $display("FAIL err_after_rst got err=%b stall=%0d frz=%b exp 0 0 0", mem_err, stall_cnt, freeze_all);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    fwd_en = 1'b0; exe_wb_en = 1'b1; exe_dest = 5'd9; id_src1 = 5'd9;
    tick();
    #1;
    checks++;
    if (outs !== 5'b01101) begin
      errors++; $display("FAIL b2b_second_stall got %b exp %b", outs, 5'b01101);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (stall_cnt !== 16'd2) begin
      errors++; $display("FAIL b2b_stall_cnt got %0d exp %0d", stall_cnt, 2);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_raw_no_fwd();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
